// File: rtl/serial_deserializer_pkg.sv
// Shared encoder/decoder definitions: message width, bit order and receiver states.
package serial_deserializer_pkg;

  localparam int MSG_WIDTH           = 8;
  localparam bit BIT_ORDER_LSB_FIRST = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } rx_state_t;

  // Bit counter width: counts up to WIDTH-1 with a spare bit of headroom.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/serial_deserializer_if.sv
// Serial input stream plus the held message output of the deserializer.
// Handshake: a message transfers on any rising edge where messageValid && messageReady;
// messageValid and message stay stable until that edge.
interface serial_deserializer_if #(
  parameter int WIDTH = 8
) ();

  logic             serialIn;
  logic             bitValid;
  logic             frameStart;
  logic [WIDTH-1:0] message;
  logic             messageValid;
  logic             messageReady;
  logic             framingError;
  logic             overrun;

  modport master (
    output serialIn, bitValid, frameStart, messageReady,
    input  message, messageValid, framingError, overrun
  );

  modport slave (
    input  serialIn, bitValid, frameStart, messageReady,
    output message, messageValid, framingError, overrun
  );

endinterface

// File: rtl/serial_deserializer_output_buffer.sv
// One-entry valid/ready holding register; a completion that finds it full and
// not being drained is dropped and reported as a one-cycle overrun pulse.
module deser_output_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_overrun
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_overrun;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (i_load) begin
        // Loading is allowed when empty or when the held entry drains this same edge.
        if (!r_valid || i_ready) begin
          r_data  <= i_data;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_data    = r_data;
  assign o_valid   = r_valid;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/serial_deserializer.sv
// Receive-side SIPO: frames the qualified serial stream into WIDTH-bit messages,
// flags early resyncs, and hands completed messages to a one-entry output buffer.
module serial_deserializer
  import serial_deserializer_pkg::*;
#(
  parameter int WIDTH     = MSG_WIDTH,
  parameter bit LSB_FIRST = BIT_ORDER_LSB_FIRST
) (
  input  logic                 clock,
  input  logic                 reset_n,
  serial_deserializer_if.slave bus,
  output rx_state_t            o_dbg_state
);

  localparam int CW = cnt_width(WIDTH);

  rx_state_t        r_state, w_state_n;
  logic [WIDTH-1:0] r_shift, w_shift_n;
  logic [CW-1:0]    r_count, w_count_n;
  logic             r_done, w_done_n;
  logic             r_ferr, w_ferr_n;
  logic [WIDTH-1:0] w_first;

  // First bit lands in position 0 for both bit orders; MSB-first shifts it up later.
  assign w_first = {{(WIDTH-1){1'b0}}, bus.serialIn};

  always_comb begin
    w_state_n = r_state;
    w_shift_n = r_shift;
    w_count_n = r_count;
    w_done_n  = 1'b0;
    w_ferr_n  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.bitValid && bus.frameStart) begin
          w_shift_n = w_first;
          w_count_n = CW'(1);
          w_state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.bitValid) begin
          if (bus.frameStart) begin
            w_ferr_n  = 1'b1;
            w_shift_n = w_first;
            w_count_n = CW'(1);
          end else begin
            if (LSB_FIRST) begin
              for (int i = 0; i < WIDTH; i++) begin
                if (r_count == CW'(i)) w_shift_n[i] = bus.serialIn;
              end
            end else begin
              w_shift_n = {r_shift[WIDTH-2:0], bus.serialIn};
            end
            if (r_count == CW'(WIDTH - 1)) begin
              w_count_n = '0;
              w_state_n = IDLE;
              w_done_n  = 1'b1;
            end else begin
              w_count_n = r_count + CW'(1);
            end
          end
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_shift <= w_shift_n;
      r_count <= w_count_n;
      r_done  <= w_done_n;
      r_ferr  <= w_ferr_n;
    end
  end

  // r_shift still holds the finished frame on the edge after completion,
  // even if a back-to-back frame overwrites it on that same edge.
  deser_output_buffer #(.WIDTH(WIDTH)) u_out_buf (
    .clock     (clock),
    .reset_n   (reset_n),
    .i_load    (r_done),
    .i_data    (r_shift),
    .i_ready   (bus.messageReady),
    .o_data    (bus.message),
    .o_valid   (bus.messageValid),
    .o_overrun (bus.overrun)
  );

  assign bus.framingError = r_ferr;
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_serial_deserializer.sv
// Directed bench: an LSB-first and an MSB-first deserializer share one serial stream.
module tb_serial_deserializer;
  import serial_deserializer_pkg::*;

  logic clock;
  logic reset_n;
  logic serial_in, bit_valid, frame_start, msg_ready;

  rx_state_t dbg_state0, dbg_state1;

  int n_checks = 0;
  int n_fail   = 0;
  int ferr_cnt0 = 0;
  int ovr_cnt0  = 0;
  int ferr_base, ovr_base;

  serial_deserializer_if #(.WIDTH(8)) bus0 ();
  serial_deserializer_if #(.WIDTH(8)) bus1 ();

  assign bus0.serialIn     = serial_in;
  assign bus0.bitValid     = bit_valid;
  assign bus0.frameStart   = frame_start;
  assign bus0.messageReady = msg_ready;
  assign bus1.serialIn     = serial_in;
  assign bus1.bitValid     = bit_valid;
  assign bus1.frameStart   = frame_start;
  assign bus1.messageReady = msg_ready;

  serial_deserializer #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_lsb (
    .clock       (clock),
    .reset_n     (reset_n),
    .bus         (bus0.slave),
    .o_dbg_state (dbg_state0)
  );

  serial_deserializer #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_msb (
    .clock       (clock),
    .reset_n     (reset_n),
    .bus         (bus1.slave),
    .o_dbg_state (dbg_state1)
  );

  // Clock and reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Pulse counters, sampled mid-cycle
  always @(negedge clock) begin
    if (bus0.framingError === 1'b1) ferr_cnt0++;
    if (bus0.overrun === 1'b1)      ovr_cnt0++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic fs);
    serial_in   = b;
    bit_valid   = 1'b1;
    frame_start = fs;
    tick();
    bit_valid   = 1'b0;
    frame_start = 1'b0;
  endtask

  // LSB-first frame (as seen by dut_lsb), optional idle gap after each bit
  task automatic send_frame(input logic [7:0] data, input int gap);
    for (int i = 0; i < 8; i++) begin
      send_bit(data[i], i == 0);
      repeat (gap) tick();
    end
  endtask

  task automatic consume();
    msg_ready = 1'b1;
    tick();
    msg_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    logic [7:0] pat;
    reset_n = 1'b0; serial_in = 1'b0; bit_valid = 1'b0; frame_start = 1'b0; msg_ready = 1'b0;
    repeat (2) tick();
    check_eq("reset_message", bus0.message, 32'h0);
    check_eq("reset_valid", bus0.messageValid, 32'h0);
    check_eq("reset_ferr", bus0.framingError, 32'h0);
    check_eq("reset_ovr", bus0.overrun, 32'h0);
    check_eq("reset_state", dbg_state0, IDLE);
    reset_n = 1'b1;
    tick();

    // 0xA5, consecutive bits
    send_frame(8'hA5, 0);
    check_eq("a5_latency_valid", bus0.messageValid, 32'h0);
    tick();
    check_eq("a5_valid", bus0.messageValid, 32'h1);
    check_eq("a5_message", bus0.message, 32'hA5);
    check_eq("a5_no_ferr", ferr_cnt0, 32'h0);
    check_eq("a5_no_ovr", ovr_cnt0, 32'h0);
    consume();
    check_eq("a5_drained", bus0.messageValid, 32'h0);

    // 0x3C with 2-cycle gaps, held until ready
    send_frame(8'h3C, 2);
    check_eq("3c_message", bus0.message, 32'h3C);
    repeat (3) tick();
    check_eq("3c_held_valid", bus0.messageValid, 32'h1);
    check_eq("3c_held_message", bus0.message, 32'h3C);
    consume();
    check_eq("3c_drained", bus0.messageValid, 32'h0);

    // 0x11 then 0x22 back-to-back, no ready -> overrun
    ovr_base = ovr_cnt0;
    send_frame(8'h11, 0);
    send_frame(8'h22, 0);
    tick();
    check_eq("ovr_pulse", bus0.overrun, 32'h1);
    check_eq("ovr_kept_message", bus0.message, 32'h11);
    check_eq("ovr_kept_valid", bus0.messageValid, 32'h1);
    tick();
    check_eq("ovr_pulse_end", bus0.overrun, 32'h0);
    check_eq("ovr_count", ovr_cnt0 - ovr_base, 32'h1);
    consume();

    // Same, but ready on the 0x22 load edge -> replace, no overrun
    ovr_base = ovr_cnt0;
    send_frame(8'h11, 0);
    send_frame(8'h22, 0);
    msg_ready = 1'b1;
    tick();
    msg_ready = 1'b0;
    check_eq("swap_message", bus0.message, 32'h22);
    check_eq("swap_valid", bus0.messageValid, 32'h1);
    tick();
    check_eq("swap_no_ovr", ovr_cnt0 - ovr_base, 32'h0);
    consume();
    check_eq("swap_drained", bus0.messageValid, 32'h0);

    // 5 bits of 0xFF then resync with 0x0F
    ferr_base = ferr_cnt0;
    for (int i = 0; i < 5; i++) send_bit(1'b1, i == 0);
    pat = 8'h0F;
    send_bit(pat[0], 1'b1);
    check_eq("resync_ferr_pulse", bus0.framingError, 32'h1);
    for (int i = 1; i < 8; i++) send_bit(pat[i], 1'b0);
    check_eq("resync_no_early_valid", bus0.messageValid, 32'h0);
    tick();
    check_eq("resync_message", bus0.message, 32'h0F);
    check_eq("resync_valid", bus0.messageValid, 32'h1);
    check_eq("resync_ferr_count", ferr_cnt0 - ferr_base, 32'h1);
    consume();
    check_eq("resync_single_msg", bus0.messageValid, 32'h0);

    // Resync on what would have been the final bit
    ferr_base = ferr_cnt0;
    for (int i = 0; i < 7; i++) send_bit(1'b0, i == 0);
    send_frame(8'h81, 0);
    tick();
    check_eq("late_resync_message", bus0.message, 32'h81);
    check_eq("late_resync_ferr_count", ferr_cnt0 - ferr_base, 32'h1);
    consume();

    // Reset mid-frame with a message held
    send_frame(8'hC3, 0);
    tick();
    check_eq("pre_reset_message", bus0.message, 32'hC3);
    ferr_base = ferr_cnt0;
    ovr_base  = ovr_cnt0;
    pat = 8'h96;
    for (int i = 0; i < 4; i++) send_bit(pat[i], i == 0);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("async_reset_message", bus0.message, 32'h0);
    check_eq("async_reset_valid", bus0.messageValid, 32'h0);
    check_eq("async_reset_state", dbg_state0, IDLE);
    check_eq("async_reset_msb_message", bus1.message, 32'h0);
    tick();
    reset_n = 1'b1;
    tick();
    // Stray bits without frameStart and a frameStart without bitValid are ignored
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check_eq("stray_state_idle", dbg_state0, IDLE);
    send_frame(8'h5A, 0);
    tick();
    check_eq("post_reset_message", bus0.message, 32'h5A);
    check_eq("post_reset_valid", bus0.messageValid, 32'h1);
    check_eq("reset_no_pulses", (ferr_cnt0 - ferr_base) + (ovr_cnt0 - ovr_base), 32'h0);

    // Bit-order comparison between the two instances
    do_reset();
    pat = 8'b1000_0001;
    for (int i = 0; i < 8; i++) send_bit(pat[7-i], i == 0);
    tick();
    check_eq("msb_first_81", bus1.message, 32'h81);
    check_eq("lsb_first_81", bus0.message, 32'h81);
    consume();
    pat = 8'b1100_0000;
    for (int i = 0; i < 8; i++) send_bit(pat[7-i], i == 0);
    tick();
    check_eq("msb_first_c0", bus1.message, 32'hC0);
    check_eq("msb_first_c0_valid", bus1.messageValid, 32'h1);
    check_eq("lsb_first_03", bus0.message, 32'h03);
    consume();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
